// File: rtl/conv_kernel_pkg.sv
// Shared 3x3 convolution kernels, pixel types and pipeline tag for the window filter.
package conv_kernel_pkg;

   localparam int KERNEL_SIZE = 3;
   localparam int NUM_KERNELS = 4;

   typedef logic signed [7:0] coeff_t;
   typedef logic [15:0] pixel_t;
   typedef pixel_t [KERNEL_SIZE-1:0] column_t;

   typedef struct packed {
      logic        valid;
      logic [10:0] h;
      logic [9:0]  v;
   } tag_t;

   // Indexed [kernel][row][col]: 0 identity, 1 gaussian, 2 sharpen, 3 ridge.
   localparam coeff_t KERNEL_TABLE [NUM_KERNELS][KERNEL_SIZE][KERNEL_SIZE] = '{
      '{'{ 8'sd0,  8'sd0,  8'sd0}, '{ 8'sd0,  8'sd1,  8'sd0}, '{ 8'sd0,  8'sd0,  8'sd0}},
      '{'{ 8'sd1,  8'sd2,  8'sd1}, '{ 8'sd2,  8'sd4,  8'sd2}, '{ 8'sd1,  8'sd2,  8'sd1}},
      '{'{ 8'sd0, -8'sd1,  8'sd0}, '{-8'sd1,  8'sd5, -8'sd1}, '{ 8'sd0, -8'sd1,  8'sd0}},
      '{'{-8'sd1, -8'sd1, -8'sd1}, '{-8'sd1,  8'sd8, -8'sd1}, '{-8'sd1, -8'sd1, -8'sd1}}
   };

   localparam int unsigned KERNEL_SHIFT [NUM_KERNELS] = '{0, 4, 0, 0};

endpackage

// File: rtl/window_convolve_if.sv
// Column-in / pixel-out stream bundle of the window convolution filter.
interface window_convolve_if;
   import conv_kernel_pkg::*;

   column_t     line_buffer_in;
   logic [10:0] h_count_in;
   logic [9:0]  v_count_in;
   logic        data_in_valid;
   pixel_t      pixel_data_out;
   logic [10:0] h_count_out;
   logic [9:0]  v_count_out;
   logic        data_out_valid;

   modport master (
      output line_buffer_in, h_count_in, v_count_in, data_in_valid,
      input  pixel_data_out, h_count_out, v_count_out, data_out_valid
   );

   modport slave (
      input  line_buffer_in, h_count_in, v_count_in, data_in_valid,
      output pixel_data_out, h_count_out, v_count_out, data_out_valid
   );

endinterface

// File: rtl/conv_channel_mac.sv
// One colour channel of the 3x3 filter: products, adder tree, then shift and clamp,
// each behind its own register so the channel adds three cycles of latency.
module conv_channel_mac
   import conv_kernel_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int K_SELECT = 0
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WIDTH-1:0] win,
   output logic [WIDTH-1:0]                                 result
);

   localparam logic signed [15:0] MAX_VAL = 16'((1 << WIDTH) - 1);
   localparam logic [WIDTH-1:0]   MAX_OUT = '1;
   localparam int unsigned        SHIFT   = KERNEL_SHIFT[K_SELECT];

   logic signed [15:0] prod_c [KERNEL_SIZE][KERNEL_SIZE];
   logic signed [15:0] prod_q [KERNEL_SIZE][KERNEL_SIZE];
   logic signed [15:0] sum_c;
   logic signed [15:0] sum_q;
   logic signed [15:0] scaled;

   // Channel values are unsigned, so they are zero-extended before the signed multiply.
   always_comb begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            prod_c[r][c] = signed'(16'(win[r][c])) * 16'(KERNEL_TABLE[K_SELECT][r][c]);
         end
      end
   end

   always_comb begin
      sum_c = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            sum_c = sum_c + prod_q[r][c];
         end
      end
   end

   assign scaled = sum_q >>> SHIFT;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
               prod_q[r][c] <= '0;
            end
         end
         sum_q  <= '0;
         result <= '0;
      end else begin
         prod_q <= prod_c;
         sum_q  <= sum_c;
         if (scaled[15]) begin
            result <= '0;
         end else if (scaled > MAX_VAL) begin
            result <= MAX_OUT;
         end else begin
            result <= scaled[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/window_convolve.sv
// 3x3 RGB565 convolution over a sliding 3-column window with left/right edge
// replication; fixed four-cycle latency from accepted column to filtered pixel.
module window_convolve
   import conv_kernel_pkg::*;
#(
   parameter int K_SELECT = 0,
   parameter int HRES     = 1280,
   parameter int VRES     = 720
) (
   input logic              clk,
   input logic              rst,
   window_convolve_if.slave bus
);

   localparam logic [10:0] H_LAST = 11'(HRES - 1);
   localparam logic [9:0]  V_LAST = 10'(VRES - 1);

   column_t col0, col1, col2;
   column_t left_col, right_col;
   tag_t    s1_tag, s2_tag, s3_tag, s4_tag;
   tag_t    out_tag_c;

   pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] pix_win;
   logic   [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][4:0] red_win;
   logic   [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][5:0] green_win;
   logic   [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][4:0] blue_win;
   logic   [4:0] red_res;
   logic   [5:0] green_res;
   logic   [4:0] blue_res;

   // The window and its coordinates only move on accepted columns; gaps leave them intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         col0   <= '0;
         col1   <= '0;
         col2   <= '0;
         s1_tag <= '0;
      end else begin
         s1_tag.valid <= bus.data_in_valid;
         if (bus.data_in_valid) begin
            col0     <= col1;
            col1     <= col2;
            col2     <= bus.line_buffer_in;
            s1_tag.h <= bus.h_count_in;
            s1_tag.v <= bus.v_count_in;
         end
      end
   end

   // h=1 means the centre is column 0; h=0 means the centre is the previous line's last column.
   always_comb begin
      left_col  = (s1_tag.h == 11'd1) ? col1 : col0;
      right_col = (s1_tag.h == 11'd0) ? col1 : col2;
      out_tag_c = s1_tag;
      if (s1_tag.h == 11'd0) begin
         out_tag_c.h = H_LAST;
         out_tag_c.v = (s1_tag.v == 10'd0) ? V_LAST : s1_tag.v - 10'd1;
      end else begin
         out_tag_c.h = s1_tag.h - 11'd1;
      end
   end

   always_comb begin
      pix_win   = '0;
      red_win   = '0;
      green_win = '0;
      blue_win  = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         pix_win[r] = {right_col[r], col1[r], left_col[r]};
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            red_win[r][c]   = pix_win[r][c][15:11];
            green_win[r][c] = pix_win[r][c][10:5];
            blue_win[r][c]  = pix_win[r][c][4:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_tag <= '0;
         s3_tag <= '0;
         s4_tag <= '0;
      end else begin
         s2_tag <= out_tag_c;
         s3_tag <= s2_tag;
         s4_tag <= s3_tag;
      end
   end

   conv_channel_mac #(.WIDTH(5), .K_SELECT(K_SELECT)) u_red (
      .clk(clk), .rst(rst), .win(red_win), .result(red_res)
   );

   conv_channel_mac #(.WIDTH(6), .K_SELECT(K_SELECT)) u_green (
      .clk(clk), .rst(rst), .win(green_win), .result(green_res)
   );

   conv_channel_mac #(.WIDTH(5), .K_SELECT(K_SELECT)) u_blue (
      .clk(clk), .rst(rst), .win(blue_win), .result(blue_res)
   );

   assign bus.pixel_data_out = {red_res, green_res, blue_res};
   assign bus.h_count_out    = s4_tag.h;
   assign bus.v_count_out    = s4_tag.v;
   assign bus.data_out_valid = s4_tag.valid;

endmodule

// File: tb/tb_window_convolve.sv
// Directed bench for window_convolve: one instance per kernel, all fed the same
// column stream, outputs compared with hand-computed values.
module tb_window_convolve;
   import conv_kernel_pkg::*;

   logic        clk;
   logic        rst;
   column_t     lb;
   logic [10:0] h_in;
   logic [9:0]  v_in;
   logic        in_valid;

   logic [15:0] pix_out   [NUM_KERNELS];
   logic [10:0] h_out     [NUM_KERNELS];
   logic [9:0]  v_out     [NUM_KERNELS];
   logic        valid_out [NUM_KERNELS];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NUM_KERNELS; g++) begin : gen_dut
      window_convolve_if bus ();
      assign bus.line_buffer_in = lb;
      assign bus.h_count_in     = h_in;
      assign bus.v_count_in     = v_in;
      assign bus.data_in_valid  = in_valid;
      assign pix_out[g]         = bus.pixel_data_out;
      assign h_out[g]           = bus.h_count_out;
      assign v_out[g]           = bus.v_count_out;
      assign valid_out[g]       = bus.data_out_valid;

      window_convolve #(.K_SELECT(g), .HRES(1280), .VRES(720)) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic column_t flat(input logic [15:0] p);
      return {p, p, p};
   endfunction

   function automatic column_t mk_col(input logic [15:0] top, input logic [15:0] mid,
                                      input logic [15:0] bot);
      return {bot, mid, top};
   endfunction

   task automatic apply_stimulus(input column_t col, input int h, input int v);
      lb       = col;
      h_in     = 11'(h);
      v_in     = 10'(v);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Idle cycles carry junk data so an erroneous window shift would be visible.
   task automatic apply_idle(input int n);
      for (int i = 0; i < n; i++) begin
         lb       = flat(16'h5A5A);
         h_in     = 11'd1;
         v_in     = 10'd1;
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_value(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_output(input string tag, input int k, input int exp_pix,
                               input int exp_h, input int exp_v);
      check_value({tag, ".valid"}, 16'(valid_out[k]), 16'd1);
      check_value({tag, ".pix"}, pix_out[k], 16'(exp_pix));
      check_value({tag, ".h"}, 16'(h_out[k]), 16'(exp_h));
      check_value({tag, ".v"}, 16'(v_out[k]), 16'(exp_v));
   endtask

   task automatic check_idle(input string tag);
      check_value({tag, ".valid"}, 16'(valid_out[0]), 16'd0);
   endtask

   initial begin
      rst      = 1'b1;
      lb       = flat(16'hFFFF);
      h_in     = 11'd3;
      v_in     = 10'd3;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset state");
      check_idle("reset");
      check_value("reset.pix0", pix_out[0], 16'h0000);
      check_value("reset.pix1", pix_out[1], 16'h0000);
      check_value("reset.h", 16'(h_out[0]), 16'd0);
      check_value("reset.v", 16'(v_out[0]), 16'd0);
      rst = 1'b0;
      apply_idle(4);
      check_idle("reset_input_ignored");

      $display("[TB] identity ramp");
      apply_stimulus(flat(16'd8), 8, 5);
      apply_stimulus(flat(16'd9), 9, 5);
      apply_stimulus(flat(16'd10), 10, 5);
      apply_idle(1);
      check_output("ramp_h8", 0, 16'h0000, 7, 5);
      apply_idle(1);
      check_output("ramp_h9", 0, 16'h0008, 8, 5);
      apply_idle(1);
      check_output("ramp_h10", 0, 16'h0009, 9, 5);
      apply_idle(1);
      check_idle("ramp_single_valid");

      $display("[TB] flat fields");
      apply_stimulus(flat(16'hFFFF), 20, 2);
      apply_stimulus(flat(16'hFFFF), 21, 2);
      apply_stimulus(flat(16'hFFFF), 22, 2);
      apply_stimulus(flat(16'h0000), 23, 2);
      apply_stimulus(flat(16'h0000), 24, 2);
      apply_stimulus(flat(16'h0000), 25, 2);
      check_output("gauss_flat_ones", 1, 16'hFFFF, 21, 2);
      check_value("sharpen_flat_ones", pix_out[2], 16'hFFFF);
      check_value("ridge_flat_ones", pix_out[3], 16'h0000);
      apply_idle(3);
      check_output("gauss_flat_zero", 1, 16'h0000, 24, 2);

      $display("[TB] sharpen clamp");
      apply_stimulus(flat(16'hFFFF), 30, 3);
      apply_stimulus(mk_col(16'hFFFF, 16'h0000, 16'hFFFF), 31, 3);
      apply_stimulus(flat(16'hFFFF), 32, 3);
      apply_stimulus(flat(16'h0000), 33, 3);
      apply_stimulus(mk_col(16'h0000, 16'hFFFF, 16'h0000), 34, 3);
      apply_stimulus(flat(16'h0000), 35, 3);
      check_output("sharpen_clamp_low", 2, 16'h0000, 31, 3);
      check_value("ridge_clamp_low", pix_out[3], 16'h0000);
      apply_idle(3);
      check_output("sharpen_clamp_high", 2, 16'hFFFF, 34, 3);
      check_value("ridge_clamp_high", pix_out[3], 16'hFFFF);

      $display("[TB] line and frame wrap");
      apply_stimulus(flat(16'h0000), 1278, 6);
      apply_stimulus(flat(16'h0008), 1279, 6);
      apply_stimulus(flat(16'h0018), 0, 7);
      apply_stimulus(flat(16'h0000), 1, 7);
      apply_stimulus(flat(16'h0000), 2, 7);
      apply_stimulus(flat(16'h0000), 0, 0);
      check_output("wrap_right_edge", 1, 16'h0006, 1279, 6);
      apply_idle(1);
      check_output("wrap_left_edge", 1, 16'h0012, 0, 7);
      apply_idle(1);
      check_output("wrap_next", 0, 16'h0000, 1, 7);
      apply_idle(1);
      check_output("wrap_frame", 0, 16'h0000, 1279, 719);

      $display("[TB] valid gaps");
      apply_stimulus(flat(16'h0004), 40, 9);
      apply_idle(3);
      apply_stimulus(flat(16'h0008), 41, 9);
      apply_idle(3);
      apply_stimulus(flat(16'h0010), 42, 9);
      check_idle("gap_hold_a");
      apply_idle(2);
      check_idle("gap_hold_b");
      apply_idle(1);
      check_output("gap_h42", 1, 16'h0009, 41, 9);
      apply_stimulus(flat(16'h0000), 43, 9);
      apply_idle(3);
      check_output("gap_h43", 1, 16'h000A, 42, 9);

      $display("[TB] reset mid-stream");
      apply_stimulus(flat(16'hFFFF), 50, 1);
      apply_stimulus(flat(16'hFFFF), 51, 1);
      apply_stimulus(flat(16'hFFFF), 52, 1);
      rst      = 1'b1;
      lb       = flat(16'hFFFF);
      h_in     = 11'd53;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("rst_flush_a");
      apply_idle(2);
      check_idle("rst_flush_b");
      apply_stimulus(flat(16'hFFFF), 60, 2);
      check_idle("rst_latency_a");
      apply_idle(2);
      check_idle("rst_latency_b");
      apply_idle(1);
      check_output("rst_first_new", 1, 16'h39E7, 59, 2);
      apply_idle(1);
      check_idle("rst_single_valid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
